// File: rtl/word_narrower.sv
// word_narrower: splits IN_WIDTH-bit words into OUT_WIDTH-bit beats, least-significant beat first.
// Define SIGN_COMPRESS_EN to send a word whose upper bits are redundant as a single beat.
module word_narrower #(
    parameter int IN_WIDTH      = 32,
    parameter int OUT_WIDTH     = 16,
    parameter int COMPRESS_MODE = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [IN_WIDTH-1:0]  In_Data,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [OUT_WIDTH-1:0] Out_Data,
    output logic                 Out_Last,
    output logic                 Out_Compressed,
    output logic                 Busy
);

    localparam int BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || BEATS < 1) begin : g_bad_width
            $error("word_narrower: IN_WIDTH must be a positive multiple of OUT_WIDTH");
        end
        if (COMPRESS_MODE != 0 && COMPRESS_MODE != 1) begin : g_bad_mode
            $error("word_narrower: COMPRESS_MODE must be 0 or 1");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   word_q, word_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  comp_q, comp_d;

    logic                  full;
    logic                  last_beat;
    logic                  accept;
    logic                  redundant;
    logic [OUT_WIDTH-1:0]  beat;

`ifdef SIGN_COMPRESS_EN
    // Redundancy is judged on the incoming word so the decision is latched with it.
    if (BEATS > 1) begin : g_redundant
        logic [IN_WIDTH-OUT_WIDTH-1:0] ext;
        assign ext       = (COMPRESS_MODE == 1) ? {(IN_WIDTH-OUT_WIDTH){In_Data[OUT_WIDTH-1]}} : '0;
        assign redundant = (In_Data[IN_WIDTH-1:OUT_WIDTH] == ext);
    end else begin : g_single_beat
        assign redundant = 1'b1;
    end
`else
    assign redundant = 1'b0;
`endif

    always_comb begin
        beat = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (int'(cnt_q) == k) begin
                beat = word_q[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign full           = (state_q == SEND);
    assign last_beat      = full && ((cnt_q == LAST_CNT) || comp_q);
    assign Out_Valid      = full;
    assign Busy           = full;
    assign Out_Data       = full ? beat : '0;
    assign Out_Last       = last_beat;
    assign Out_Compressed = full && comp_q;
    // Ready opens combinationally on the last handshake so words stream without a bubble.
    assign In_Ready       = !Reset && (!full || (Out_Ready && last_beat));
    assign accept         = In_Valid && In_Ready;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        comp_d  = comp_q;
        if (accept) begin
            state_d = SEND;
            word_d  = In_Data;
            cnt_d   = '0;
            comp_d  = redundant;
        end else if (full && Out_Ready) begin
            if (last_beat) begin
                state_d = EMPTY;
                cnt_d   = '0;
                comp_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= EMPTY;
            word_q  <= '0;
            cnt_q   <= '0;
            comp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            comp_q  <= comp_d;
        end
    end

endmodule

// File: tb/tb_word_narrower.sv
// tb_word_narrower: directed table, corner sequences and a random scoreboard run for word_narrower.
// Builds with or without SIGN_COMPRESS_EN; the DUT is configured with COMPRESS_MODE=1.
module tb_word_narrower;

    localparam int IW = 32;
    localparam int OW = 16;
`ifdef SIGN_COMPRESS_EN
    localparam bit COMP_ON = 1'b1;
`else
    localparam bit COMP_ON = 1'b0;
`endif

    logic          Clk;
    logic          Reset;
    logic          In_Valid;
    logic          In_Ready;
    logic [IW-1:0] In_Data;
    logic          Out_Valid;
    logic          Out_Ready;
    logic [OW-1:0] Out_Data;
    logic          Out_Last;
    logic          Out_Compressed;
    logic          Busy;

    int total_checks = 0;
    int bad_checks   = 0;

    word_narrower #(
        .IN_WIDTH      (IW),
        .OUT_WIDTH     (OW),
        .COMPRESS_MODE (1)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .In_Valid       (In_Valid),
        .In_Ready       (In_Ready),
        .In_Data        (In_Data),
        .Out_Valid      (Out_Valid),
        .Out_Ready      (Out_Ready),
        .Out_Data       (Out_Data),
        .Out_Last       (Out_Last),
        .Out_Compressed (Out_Compressed),
        .Busy           (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [IW-1:0] word;
        logic [OW-1:0] lo;
        logic [OW-1:0] hi;
        int            nbeats;
    } vec_t;

    typedef struct {
        logic [OW-1:0] data;
        bit            last;
        bit            comp;
    } beat_t;

    vec_t  vecs[6];
    beat_t model_q[$];

    task automatic applyStimulus(input logic rst, input logic iv, input logic [IW-1:0] data,
                                 input logic ordy);
        Reset     = rst;
        In_Valid  = iv;
        In_Data   = data;
        Out_Ready = ordy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    // Mode-1 redundancy: the word is just the low halfword sign-extended.
    function automatic bit isRedundant(input logic [IW-1:0] w);
        int whole;
        int low;
        whole = w;
        low   = $signed(w[OW-1:0]);
        return COMP_ON && (whole == low);
    endfunction

    function automatic logic [IW-1:0] randomWord();
        logic [IW-1:0] w;
        int            s;
        case ($urandom_range(0, 3))
            0: w = $urandom;
            1: w = $urandom_range(0, 32767);
            2: begin
                s = $signed(16'($urandom_range(32768, 65535)));
                w = s;
            end
            default: w = 32'h0000_8000 | 32'($urandom_range(0, 32767));
        endcase
        return w;
    endfunction

    task automatic sendTableVector(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        applyStimulus(1'b0, 1'b1, v.word, 1'b1);
        checkOutput({tag, "_in_ready"}, 32'(In_Ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, $urandom, 1'b1);
        checkOutput({tag, "_b0_valid"}, 32'(Out_Valid), 32'd1);
        checkOutput({tag, "_b0_busy"}, 32'(Busy), 32'd1);
        checkOutput({tag, "_b0_data"}, 32'(Out_Data), 32'(v.lo));
        checkOutput({tag, "_b0_last"}, 32'(Out_Last), 32'(v.nbeats == 1));
        checkOutput({tag, "_b0_comp"}, 32'(Out_Compressed), 32'(v.nbeats == 1));
        nextCycle();
        if (v.nbeats == 2) begin
            applyStimulus(1'b0, 1'b0, $urandom, 1'b1);
            checkOutput({tag, "_b1_data"}, 32'(Out_Data), 32'(v.hi));
            checkOutput({tag, "_b1_last"}, 32'(Out_Last), 32'd1);
            checkOutput({tag, "_b1_comp"}, 32'(Out_Compressed), 32'd0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, $urandom, 1'b1);
        checkOutput({tag, "_idle_valid"}, 32'(Out_Valid), 32'd0);
        nextCycle();
    endtask

    initial begin
        logic       exp_valid;
        logic       exp_ready;
        logic       iv;
        logic       ordy;
        logic [IW-1:0] w;
        beat_t      b;

        vecs[0] = '{32'h1234_ABCD, 16'hABCD, 16'h1234, 2};
        vecs[1] = '{32'hFFFF_8000, 16'h8000, 16'hFFFF, COMP_ON ? 1 : 2};
        vecs[2] = '{32'hFFFF_0001, 16'h0001, 16'hFFFF, 2};
        vecs[3] = '{32'h0000_0005, 16'h0005, 16'h0000, COMP_ON ? 1 : 2};
        vecs[4] = '{32'h0000_8000, 16'h8000, 16'h0000, 2};
        vecs[5] = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, COMP_ON ? 1 : 2};

        // Reset held for three edges with a word offered the whole time.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h5555_5555, 1'b0);
            checkOutput($sformatf("rst%0d_in_ready", i), 32'(In_Ready), 32'd0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_out_valid", 32'(Out_Valid), 32'd0);
        checkOutput("rst_out_data", 32'(Out_Data), 32'd0);
        checkOutput("rst_out_last", 32'(Out_Last), 32'd0);
        checkOutput("rst_out_comp", 32'(Out_Compressed), 32'd0);
        checkOutput("rst_busy", 32'(Busy), 32'd0);
        checkOutput("rst_in_ready_after", 32'(In_Ready), 32'd1);
        nextCycle();

        for (int i = 0; i < 6; i++) begin
            sendTableVector(vecs[i], i);
        end

        // Stall on beat 0 while another word is offered and must be ignored.
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h1111_2222, 1'b0);
            checkOutput($sformatf("stall%0d_data", i), 32'(Out_Data), 32'hBEEF);
            checkOutput($sformatf("stall%0d_in_ready", i), 32'(In_Ready), 32'd0);
            checkOutput($sformatf("stall%0d_last", i), 32'(Out_Last), 32'd0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("stall_release_data", 32'(Out_Data), 32'hBEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("stall_hi_data", 32'(Out_Data), 32'hDEAD);
        checkOutput("stall_hi_last", 32'(Out_Last), 32'd1);
        checkOutput("stall_hi_in_ready", 32'(In_Ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("stall_done_valid", 32'(Out_Valid), 32'd0);
        nextCycle();

        // Back-to-back words with no idle cycle between them.
        applyStimulus(1'b0, 1'b1, 32'h0001_0002, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h0003_0004, 1'b1);
        checkOutput("b2b_w0b0_data", 32'(Out_Data), 32'h0002);
        checkOutput("b2b_w0b0_in_ready", 32'(In_Ready), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h0003_0004, 1'b1);
        checkOutput("b2b_w0b1_data", 32'(Out_Data), 32'h0001);
        checkOutput("b2b_w0b1_in_ready", 32'(In_Ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("b2b_w1b0_valid", 32'(Out_Valid), 32'd1);
        checkOutput("b2b_w1b0_data", 32'(Out_Data), 32'h0004);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("b2b_w1b1_data", 32'(Out_Data), 32'h0003);
        checkOutput("b2b_w1b1_last", 32'(Out_Last), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("b2b_done_valid", 32'(Out_Valid), 32'd0);
        nextCycle();

        // Reset after beat 0 discards the rest of the word.
        applyStimulus(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("midrst_b0_data", 32'(Out_Data), 32'hF00D);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("midrst_in_ready", 32'(In_Ready), 32'd0);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput($sformatf("midrst%0d_valid", i), 32'(Out_Valid), 32'd0);
            checkOutput($sformatf("midrst%0d_data", i), 32'(Out_Data), 32'd0);
            nextCycle();
        end

        // Random traffic against a queue of expected beats; the queue head is the beat on the bus.
        model_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            w    = randomWord();
            applyStimulus(1'b0, iv, w, ordy);
            exp_valid = (model_q.size() != 0);
            exp_ready = !exp_valid || (ordy && model_q[0].last);
            checkOutput("rnd_out_valid", 32'(Out_Valid), 32'(exp_valid));
            checkOutput("rnd_in_ready", 32'(In_Ready), 32'(exp_ready));
            if (exp_valid) begin
                checkOutput("rnd_out_data", 32'(Out_Data), 32'(model_q[0].data));
                checkOutput("rnd_out_last", 32'(Out_Last), 32'(model_q[0].last));
                checkOutput("rnd_out_comp", 32'(Out_Compressed), 32'(model_q[0].comp));
            end
            if (exp_valid && ordy) begin
                void'(model_q.pop_front());
            end
            if (iv && exp_ready) begin
                if (isRedundant(w)) begin
                    b.data = w[OW-1:0];
                    b.last = 1'b1;
                    b.comp = 1'b1;
                    model_q.push_back(b);
                end else begin
                    for (int k = 0; k < IW / OW; k++) begin
                        b.data = OW'(w >> (k * OW));
                        b.last = (k == IW / OW - 1);
                        b.comp = 1'b0;
                        model_q.push_back(b);
                    end
                end
            end
            nextCycle();
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
